hp_mul_round_pipe: RTL and testbench

HP_MUL_ROUND_PIPE -- requirements
Module: hp_mul_round_pipe

---
 rtl/hp_mul_round_pipe.sv | 179 +++++++++++++++++
 tb/tb_hp_mul_round_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hp_mul_round_pipe.sv
// Normalize/round back end of the binary16 multiplier.
// Two-stage valid/ready pipeline: normalize, then round and classify.
package hp_mul_round_pkg;

  typedef struct packed {
    logic       sign;
    logic [6:0] exp;
    logic [9:0] mant;
    logic       guard;
    logic       sticky;
    logic       zero;
    logic       inv;
  } s1_t;

  typedef struct packed {
    logic [15:0] result;
    logic [1:0]  exc;
  } s2_t;

  localparam logic [1:0] EXC_OK  = 2'b00;
  localparam logic [1:0] EXC_OVF = 2'b01;
  localparam logic [1:0] EXC_UNF = 2'b10;
  localparam logic [1:0] EXC_INV = 2'b11;

endpackage

module hp_mul_round_pipe
  import hp_mul_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [21:0] in_prod,
  input  logic        in_zero,
  input  logic [1:0]  in_exc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [1:0]  out_exc,
  output logic [7:0]  ovf_cnt,
  output logic [7:0]  unf_cnt
);

  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic       s1_valid_q;
  logic       s2_valid_q;
  logic [7:0] ovf_cnt_q;
  logic [7:0] unf_cnt_q;

  logic       s2_adv;
  logic       in_fire;
  logic       s1_move;
  logic       out_fire;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready;
  assign s1_move  = s1_valid_q && s2_adv;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.zero = in_zero;
    s1_d.inv  = (in_exc == EXC_INV);
    if (in_prod[21]) begin
      s1_d.mant   = in_prod[20:11];
      s1_d.guard  = in_prod[10];
      s1_d.sticky = |in_prod[9:0];
      s1_d.exp    = in_exp - 7'd14;
    end else begin
      s1_d.mant   = in_prod[19:10];
      s1_d.guard  = in_prod[9];
      s1_d.sticky = |in_prod[8:0];
      s1_d.exp    = in_exp - 7'd15;
    end
  end

  logic        rnd;
  logic [10:0] mant_sum;
  logic [7:0]  exp_r;
  logic        is_ovf;
  logic        is_unf;
  logic        sel_inv;
  logic        sel_zero;
  logic        sel_ovf;
  logic        sel_unf;
  logic        sel_norm;

  // exp_r is signed two's complement; bit 7 marks a negative exponent
  always_comb begin
    rnd      = s1_q.guard && (s1_q.sticky || s1_q.mant[0]);
    mant_sum = {1'b0, s1_q.mant} + {10'b0, rnd};
    exp_r    = {s1_q.exp[6], s1_q.exp} + {7'b0, mant_sum[10]};
    is_ovf   = !exp_r[7] && (exp_r >= 8'd31);
    is_unf   = exp_r[7] || (exp_r == 8'd0);
    sel_inv  = s1_q.inv;
    sel_zero = !s1_q.inv && s1_q.zero;
    sel_ovf  = !s1_q.inv && !s1_q.zero && is_ovf;
    sel_unf  = !s1_q.inv && !s1_q.zero && !is_ovf && is_unf;
    sel_norm = !s1_q.inv && !s1_q.zero && !is_ovf && !is_unf;
  end

  always_comb begin
    s2_d = '0;
    unique case (1'b1)
      sel_inv: begin
        s2_d.result = 16'h7E00;
        s2_d.exc    = EXC_INV;
      end
      sel_zero: begin
        s2_d.result = {s1_q.sign, 15'h0};
        s2_d.exc    = EXC_OK;
      end
      sel_ovf: begin
        s2_d.result = {s1_q.sign, 5'h1F, 10'h0};
        s2_d.exc    = EXC_OVF;
      end
      sel_unf: begin
        s2_d.result = {s1_q.sign, 15'h0};
        s2_d.exc    = EXC_UNF;
      end
      sel_norm: begin
        s2_d.result = {s1_q.sign, exp_r[4:0], mant_sum[9:0]};
        s2_d.exc    = EXC_OK;
      end
      default: s2_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_q       <= s1_d;
    end else if (s1_move) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_q <= s2_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else if (out_fire) begin
      if (s2_q.exc == EXC_OVF && ovf_cnt_q != 8'hFF) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
      if (s2_q.exc == EXC_UNF && unf_cnt_q != 8'hFF) begin
        unf_cnt_q <= unf_cnt_q + 8'd1;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_q.result;
  assign out_exc    = s2_q.exc;
  assign ovf_cnt    = ovf_cnt_q;
  assign unf_cnt    = unf_cnt_q;

endmodule

// File: tb/tb_hp_mul_round_pipe.sv
// Directed bench for hp_mul_round_pipe.
// Hand-computed binary16 vectors, stall, saturation and reset checks.
module tb_hp_mul_round_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_prod;
  logic        in_zero;
  logic [1:0]  in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [1:0]  out_exc;
  logic [7:0]  ovf_cnt;
  logic [7:0]  unf_cnt;

  int total = 0;
  int bad   = 0;
  int vcnt;

  always #5 clk = ~clk;

  hp_mul_round_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_zero    (in_zero),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_exc    (out_exc),
    .ovf_cnt    (ovf_cnt),
    .unf_cnt    (unf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [6:0] e,
                       input logic [21:0] p, input logic z,
                       input logic [1:0] x);
    in_sign = s;
    in_exp  = e;
    in_prod = p;
    in_zero = z;
    in_exc  = x;
  endtask

  task automatic run_vec(input string tag, input logic s,
                         input logic [6:0] e, input logic [21:0] p,
                         input logic z, input logic [1:0] x,
                         input logic [15:0] res, input logic [1:0] ex);
    drive(s, e, p, z, x);
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(out_result), 32'(res));
    chk({tag, "_exc"}, 32'(out_exc), 32'(ex));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 7'd0, 22'h0, 1'b0, 2'b00);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'h0);
    chk("rst_exc", 32'(out_exc), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_unf", 32'(unf_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    run_vec("m5x6", 1'b0, 7'd34, 22'h1E0000, 1'b0, 2'b00, 16'h4F80, 2'b00);
    run_vec("m3x3", 1'b0, 7'd32, 22'h240000, 1'b0, 2'b00, 16'h4880, 2'b00);
    run_vec("rnd_up", 1'b0, 7'd30, 22'h100600, 1'b0, 2'b00, 16'h3C02, 2'b00);
    run_vec("rnd_tie", 1'b0, 7'd30, 22'h100200, 1'b0, 2'b00, 16'h3C00, 2'b00);
    run_vec("rnd_cy", 1'b0, 7'd30, 22'h1FFE00, 1'b0, 2'b00, 16'h4000, 2'b00);
    run_vec("ovf", 1'b1, 7'd60, 22'h3FF001, 1'b0, 2'b00, 16'hFC00, 2'b01);
    chk("ovf_cnt1", 32'(ovf_cnt), 32'd1);
    run_vec("unf", 1'b0, 7'd10, 22'h100000, 1'b0, 2'b00, 16'h0000, 2'b10);
    chk("unf_cnt1", 32'(unf_cnt), 32'd1);
    run_vec("inv", 1'b0, 7'd30, 22'h2ABCDE, 1'b1, 2'b11, 16'h7E00, 2'b11);
    run_vec("zero", 1'b1, 7'd30, 22'h1FFE00, 1'b1, 2'b00, 16'h8000, 2'b00);
    chk("cnt_hold_ovf", 32'(ovf_cnt), 32'd1);

    out_ready = 1'b0;
    drive(1'b0, 7'd34, 22'h1E0000, 1'b0, 2'b00);
    in_valid = 1'b1;
    chk("st_rdyA", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 7'd32, 22'h240000, 1'b0, 2'b00);
    chk("st_rdyB", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 7'd30, 22'h100600, 1'b0, 2'b00);
    chk("st_rdyC", 32'(in_ready), 32'd0);
    chk("st_A0", 32'(out_result), 32'h4F80);
    tick();
    chk("st_full", 32'(in_ready), 32'd0);
    chk("st_hold_v", 32'(out_valid), 32'd1);
    chk("st_hold", 32'(out_result), 32'h4F80);
    out_ready = 1'b1;
    #1;
    chk("st_rdy_go", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("st_B_v", 32'(out_valid), 32'd1);
    chk("st_B", 32'(out_result), 32'h4880);
    tick();
    chk("st_C_v", 32'(out_valid), 32'd1);
    chk("st_C", 32'(out_result), 32'h3C02);
    tick();
    chk("st_empty", 32'(out_valid), 32'd0);

    drive(1'b1, 7'd60, 22'h3FF001, 1'b0, 2'b00);
    in_valid = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (out_valid) vcnt++;
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_thru", 32'(vcnt), 32'd299);
    chk("sat_ovf", 32'(ovf_cnt), 32'hFF);
    chk("sat_unf", 32'(unf_cnt), 32'd1);

    out_ready = 1'b0;
    drive(1'b0, 7'd10, 22'h100000, 1'b0, 2'b00);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("mid_v", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_res", 32'(out_result), 32'h0);
    chk("mid_rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("mid_rst_unf", 32'(unf_cnt), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_nv", 32'(out_valid), 32'd0);
      tick();
    end
    chk("post_rst_unf", 32'(unf_cnt), 32'd0);
    run_vec("post", 1'b0, 7'd32, 22'h240000, 1'b0, 2'b00, 16'h4880, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
